// File: rtl/alu_bus_master.sv
// rtl/alu_bus_master.sv - sequences one ALU operation over the single-bus command interface
module alu_bus_master #(
    parameter int WORDSIZE  = 16,
    parameter int CMD_WIDTH = 4,
    parameter logic [CMD_WIDTH-1:0] COM_NOP     = CMD_WIDTH'(0),
    parameter logic [CMD_WIDTH-1:0] COM_LATCHA  = CMD_WIDTH'(1),
    parameter logic [CMD_WIDTH-1:0] COM_LATCHB  = CMD_WIDTH'(2),
    parameter logic [CMD_WIDTH-1:0] COM_LATCHF  = CMD_WIDTH'(3),
    parameter logic [CMD_WIDTH-1:0] COM_LATCHOP = CMD_WIDTH'(4),
    parameter logic [CMD_WIDTH-1:0] COM_COMPUTE = CMD_WIDTH'(5),
    parameter logic [CMD_WIDTH-1:0] COM_OUTPUTY = CMD_WIDTH'(6),
    parameter logic [CMD_WIDTH-1:0] COM_OUTPUTF = CMD_WIDTH'(7)
) (
    input  logic                 i_Clk,
    input  logic                 i_Reset_n,
    input  logic                 i_req_valid,
    output logic                 o_req_ready,
    input  logic [WORDSIZE-1:0]  i_req_a,
    input  logic [WORDSIZE-1:0]  i_req_b,
    input  logic [3:0]           i_req_op,
    input  logic                 i_req_load_f,
    input  logic [WORDSIZE-1:0]  i_req_f,
    output logic                 o_rsp_valid,
    input  logic                 i_rsp_ready,
    output logic [WORDSIZE-1:0]  o_rsp_y,
    output logic [WORDSIZE-1:0]  o_rsp_f,
    output logic                 o_rsp_err,
    output logic [CMD_WIDTH-1:0] o_bus_command,
    output logic [WORDSIZE-1:0]  o_bus_data,
    output logic                 o_bus_valid,
    input  logic [WORDSIZE-1:0]  i_bus_data,
    input  logic                 i_bus_valid
);

    typedef enum logic [3:0] {
        IDLE, LA, LB, LOP, LF, COMP, RDY, RDF, RESP
    } state_t;

    state_t               state, state_next;
    logic [WORDSIZE-1:0]  a_q, b_q, f_q;
    logic [3:0]           op_q;
    logic                 load_f_q;
    logic [CMD_WIDTH-1:0] cmd_next;
    logic [WORDSIZE-1:0]  data_next;
    logic                 valid_next;

    assign o_req_ready = (state == IDLE);
    assign o_rsp_valid = (state == RESP);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (i_req_valid) state_next = LA;
            LA:      state_next = LB;
            LB:      state_next = LOP;
            LOP:     state_next = load_f_q ? LF : COMP;
            LF:      state_next = COMP;
            COMP:    state_next = RDY;
            RDY:     state_next = RDF;
            RDF:     state_next = RESP;
            RESP:    if (i_rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Bus outputs are computed for the state being entered so they register
    // alongside it; LA is only reachable from IDLE, so it drives the raw input.
    always_comb begin
        cmd_next   = COM_NOP;
        data_next  = '0;
        valid_next = 1'b0;
        case (state_next)
            LA: begin
                cmd_next   = COM_LATCHA;
                data_next  = i_req_a;
                valid_next = 1'b1;
            end
            LB: begin
                cmd_next   = COM_LATCHB;
                data_next  = b_q;
                valid_next = 1'b1;
            end
            LOP: begin
                cmd_next       = COM_LATCHOP;
                data_next[3:0] = op_q;
                valid_next     = 1'b1;
            end
            LF: begin
                cmd_next   = COM_LATCHF;
                data_next  = f_q;
                valid_next = 1'b1;
            end
            COMP:    cmd_next = COM_COMPUTE;
            RDY:     cmd_next = COM_OUTPUTY;
            RDF:     cmd_next = COM_OUTPUTF;
            default: cmd_next = COM_NOP;
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Reset_n) begin
            state         <= IDLE;
            o_bus_command <= COM_NOP;
            o_bus_data    <= '0;
            o_bus_valid   <= 1'b0;
            o_rsp_y       <= '0;
            o_rsp_f       <= '0;
            o_rsp_err     <= 1'b0;
            a_q           <= '0;
            b_q           <= '0;
            f_q           <= '0;
            op_q          <= '0;
            load_f_q      <= 1'b0;
        end else begin
            state         <= state_next;
            o_bus_command <= cmd_next;
            o_bus_data    <= data_next;
            o_bus_valid   <= valid_next;
            if (state == IDLE && i_req_valid) begin
                a_q       <= i_req_a;
                b_q       <= i_req_b;
                op_q      <= i_req_op;
                load_f_q  <= i_req_load_f;
                f_q       <= i_req_f;
                o_rsp_err <= 1'b0;
            end
            if (state == RDY) begin
                o_rsp_y <= i_bus_data;
                if (!i_bus_valid) o_rsp_err <= 1'b1;
            end
            if (state == RDF) begin
                o_rsp_f <= i_bus_data;
                if (!i_bus_valid) o_rsp_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alu_bus_master.sv
// tb/tb_alu_bus_master.sv - self-checking bench for alu_bus_master with a bus-level ALU model
module tb_alu_bus_master;
    localparam logic [3:0] C_NOP = 4'd0, C_LATCHA = 4'd1, C_LATCHB = 4'd2, C_LATCHF = 4'd3;
    localparam logic [3:0] C_LATCHOP = 4'd4, C_COMPUTE = 4'd5, C_OUTPUTY = 4'd6, C_OUTPUTF = 4'd7;
    localparam logic [3:0] ALU_ADD = 4'd1, ALU_ADC = 4'd2, ALU_SUB = 4'd3;
    localparam logic [3:0] ALU_AND = 4'd4, ALU_OR = 4'd5, ALU_XOR = 4'd6;
    localparam int F_CARRY = 0;
    localparam int F_ERROR = 3;

    logic        clk, resetn;
    logic        req_valid, req_ready, req_load_f;
    logic [15:0] req_a, req_b, req_f;
    logic [3:0]  req_op;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [15:0] rsp_y, rsp_f;
    logic [3:0]  bus_command;
    logic [15:0] bus_data, bus_rdata;
    logic        bus_valid, bus_rvalid;

    int checks = 0;
    int failures = 0;

    alu_bus_master #(
        .WORDSIZE(16), .CMD_WIDTH(4),
        .COM_NOP(C_NOP), .COM_LATCHA(C_LATCHA), .COM_LATCHB(C_LATCHB), .COM_LATCHF(C_LATCHF),
        .COM_LATCHOP(C_LATCHOP), .COM_COMPUTE(C_COMPUTE), .COM_OUTPUTY(C_OUTPUTY),
        .COM_OUTPUTF(C_OUTPUTF)
    ) dut (
        .i_Clk(clk), .i_Reset_n(resetn),
        .i_req_valid(req_valid), .o_req_ready(req_ready),
        .i_req_a(req_a), .i_req_b(req_b), .i_req_op(req_op),
        .i_req_load_f(req_load_f), .i_req_f(req_f),
        .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
        .o_rsp_y(rsp_y), .o_rsp_f(rsp_f), .o_rsp_err(rsp_err),
        .o_bus_command(bus_command), .o_bus_data(bus_data), .o_bus_valid(bus_valid),
        .i_bus_data(bus_rdata), .i_bus_valid(bus_rvalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Returns {y, flags} for one ALU operation.
    function automatic logic [31:0] alu_math(input logic [15:0] a, b, input logic [3:0] op,
                                             input logic [15:0] fin);
        logic [16:0] s;
        logic [15:0] f;
        f = '0;
        case (op)
            ALU_ADD: s = 17'(a) + 17'(b);
            ALU_ADC: s = 17'(a) + 17'(b) + 17'(fin[F_CARRY]);
            ALU_SUB: s = 17'(a) - 17'(b);
            ALU_AND: s = {1'b0, a & b};
            ALU_OR:  s = {1'b0, a | b};
            ALU_XOR: s = {1'b0, a ^ b};
            default: begin s = '0; f[F_ERROR] = 1'b1; end
        endcase
        f[F_CARRY] = s[16];
        return {s[15:0], f};
    endfunction

    logic [15:0] alu_a = '0, alu_b = '0, alu_f = '0, alu_y = '0;
    logic [3:0]  alu_op = '0;
    int          compute_count = 0;
    logic        bad_y = 1'b0, bad_f = 1'b0;

    always @(posedge clk) begin
        logic [31:0] r;
        case (bus_command)
            C_LATCHA:  if (bus_valid) alu_a <= bus_data;
            C_LATCHB:  if (bus_valid) alu_b <= bus_data;
            C_LATCHOP: if (bus_valid) alu_op <= bus_data[3:0];
            C_LATCHF:  if (bus_valid) alu_f <= bus_data;
            C_COMPUTE: begin
                r = alu_math(alu_a, alu_b, alu_op, alu_f);
                alu_y <= r[31:16];
                alu_f <= r[15:0];
                compute_count <= compute_count + 1;
            end
            default: ;
        endcase
    end

    always_comb begin
        bus_rdata  = '0;
        bus_rvalid = 1'b0;
        if (bus_command == C_OUTPUTY) begin
            bus_rdata  = alu_y;
            bus_rvalid = !bad_y;
        end else if (bus_command == C_OUTPUTF) begin
            bus_rdata  = alu_f;
            bus_rvalid = !bad_f;
        end
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic check_reset_values(input string nm);
        check({nm, ".req_ready"}, req_ready, 1);
        check({nm, ".bus"}, {bus_command, bus_valid, bus_data}, {C_NOP, 1'b0, 16'h0});
        check({nm, ".rsp"}, {rsp_valid, rsp_err, rsp_y, rsp_f}, {1'b0, 1'b0, 16'h0, 16'h0});
    endtask

    task automatic run_txn(input string nm, input logic [15:0] a, b, input logic [3:0] op,
                           input logic lf, input logic [15:0] f, input int hold,
                           input logic by, input logic bf,
                           input logic [15:0] ey, input logic [15:0] ef, input logic ee);
        logic [3:0] exp_cmds[$];
        logic [3:0] got_cmds[$];
        int n;
        @(negedge clk);
        check({nm, ".req_ready"}, req_ready, 1);
        bad_y = by; bad_f = bf;
        req_a = a; req_b = b; req_op = op; req_load_f = lf; req_f = f;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 30) begin
            @(negedge clk);
            n++;
            if (!rsp_valid) got_cmds.push_back(bus_command);
        end
        check({nm, ".latency"}, n, lf ? 8 : 7);
        exp_cmds = '{C_LATCHA, C_LATCHB, C_LATCHOP};
        if (lf) exp_cmds.push_back(C_LATCHF);
        exp_cmds.push_back(C_COMPUTE);
        exp_cmds.push_back(C_OUTPUTY);
        exp_cmds.push_back(C_OUTPUTF);
        check({nm, ".ncmds"}, got_cmds.size(), exp_cmds.size());
        for (int i = 0; i < exp_cmds.size() && i < got_cmds.size(); i++)
            check($sformatf("%s.cmd%0d", nm, i), got_cmds[i], exp_cmds[i]);
        check({nm, ".y"}, rsp_y, ey);
        check({nm, ".f"}, rsp_f, ef);
        check({nm, ".err"}, rsp_err, ee);
        check({nm, ".resp_bus"}, {req_ready, bus_command, bus_valid}, {1'b0, C_NOP, 1'b0});
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check($sformatf("%s.hold%0d", nm, i),
                  {rsp_valid, req_ready, bus_command, rsp_err, rsp_y, rsp_f},
                  {1'b1, 1'b0, C_NOP, ee, ey, ef});
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        bad_y = 1'b0; bad_f = 1'b0;
        check({nm, ".idle"}, {rsp_valid, req_ready}, 2'b01);
    endtask

    typedef struct {
        logic [15:0] a, b;
        logic [3:0]  op;
        logic        lf;
        logic [15:0] f;
        int          hold;
        logic        by;
        logic [15:0] ey, ef;
        logic        ee;
    } vec_t;

    vec_t vt[8];
    logic [15:0] ref_flags;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{16'h1234, 16'h0001, ALU_ADD, 1'b0, 16'h0, 0,  1'b0, 16'h1235, 16'h0000, 1'b0};
        vt[1] = '{16'hFFFF, 16'h0002, ALU_ADD, 1'b0, 16'h0, 0,  1'b0, 16'h0001, 16'h0001, 1'b0};
        vt[2] = '{16'h0001, 16'h0001, ALU_ADC, 1'b0, 16'h0, 0,  1'b0, 16'h0003, 16'h0000, 1'b0};
        vt[3] = '{16'h0001, 16'h0001, ALU_ADC, 1'b1, 16'h0, 0,  1'b0, 16'h0002, 16'h0000, 1'b0};
        vt[4] = '{16'h0005, 16'h0006, 4'hF,    1'b0, 16'h0, 0,  1'b0, 16'h0000, 16'h0008, 1'b0};
        vt[5] = '{16'h0002, 16'h0003, ALU_ADD, 1'b0, 16'h0, 0,  1'b1, 16'h0005, 16'h0000, 1'b1};
        vt[6] = '{16'h0007, 16'h0008, ALU_ADD, 1'b0, 16'h0, 0,  1'b0, 16'h000F, 16'h0000, 1'b0};
        vt[7] = '{16'h00FF, 16'h0F0F, ALU_AND, 1'b0, 16'h0, 10, 1'b0, 16'h000F, 16'h0000, 1'b0};

        resetn = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
        req_a = '0; req_b = '0; req_op = '0; req_load_f = 1'b0; req_f = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_values("reset");
        resetn = 1'b1;

        for (int i = 0; i < 8; i++)
            run_txn($sformatf("vec%0d", i), vt[i].a, vt[i].b, vt[i].op, vt[i].lf, vt[i].f,
                    vt[i].hold, vt[i].by, 1'b0, vt[i].ey, vt[i].ef, vt[i].ee);

        // Leave nonzero y/f/err behind so the mid-sequence reset is observable.
        run_txn("pre_rst", 16'hFFFF, 16'h0002, ALU_ADD, 1'b0, 16'h0, 0, 1'b1, 1'b0,
                16'h0001, 16'h0001, 1'b1);
        @(negedge clk);
        req_a = 16'h1111; req_b = 16'h2222; req_op = ALU_ADD; req_load_f = 1'b0;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("rst_lb.la", bus_command, C_LATCHA);
        @(negedge clk);
        check("rst_lb.lb", bus_command, C_LATCHB);
        resetn = 1'b0;
        begin
            int cc;
            cc = compute_count;
            @(posedge clk);
            #1 check_reset_values("rst_lb");
            @(negedge clk);
            resetn = 1'b1;
            repeat (6) @(negedge clk);
            check("rst_lb.no_compute", compute_count, cc);
        end
        run_txn("post_rst", 16'h0003, 16'h0004, ALU_ADD, 1'b1, 16'h0, 0, 1'b0, 1'b0,
                16'h0007, 16'h0000, 1'b0);
        ref_flags = 16'h0000;

        for (int i = 0; i < 40; i++) begin
            logic [15:0] a, b, f;
            logic [3:0]  op;
            logic        lf, by, bf;
            logic [31:0] r;
            int          hold;
            a = 16'($urandom); b = 16'($urandom); f = 16'($urandom);
            op = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 0) op = ALU_ADC;
            lf = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            by = ($urandom_range(0, 7) == 0);
            bf = ($urandom_range(0, 7) == 0);
            hold = $urandom_range(0, 3);
            if (lf) ref_flags = f;
            r = alu_math(a, b, op, ref_flags);
            ref_flags = r[15:0];
            run_txn($sformatf("rnd%0d", i), a, b, op, lf, f, hold, by, bf,
                    r[31:16], r[15:0], by | bf);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
